// File: rtl/pc_sequencer_if.sv
// Instruction-memory fetch handshake between pc_sequencer (master) and the memory (slave).
// imem_rdata is valid in the same cycle as imem_ack.
interface pc_sequencer_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: fetch over imem handshake, wait for execution, pick next PC.
// Optional feature macro PC_BOUNDS_EN: out-of-range branch/jump targets trap into a sticky FAULT state.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'd0,
  parameter int unsigned IMEM_DEPTH = 1024,
  parameter int unsigned LINK_REG   = 31
) (
  input  logic                  clk,
  input  logic                  rst,
  pc_sequencer_if.master        imem,
  output logic [31:0]           ir_out,
  output logic                  ir_valid,
  input  logic                  exec_valid,
  input  logic [31:0]           instr_ID,
  input  logic [31:0]           br_out,
  output logic [31:0]           pc,
  output logic                  flush,
  output logic                  link_we,
  output logic [4:0]            link_addr,
  output logic [31:0]           link_data,
  output logic                  pc_fault
);

  if ((IMEM_DEPTH & (IMEM_DEPTH - 1)) != 0 || IMEM_DEPTH == 0) begin : g_depth_check
    $error("IMEM_DEPTH must be a power of 2");
  end

  localparam logic [31:0] ADDR_MASK = 32'(IMEM_DEPTH - 1);
`ifdef PC_BOUNDS_EN
  localparam logic [31:0] DEPTH_W   = 32'(IMEM_DEPTH);
`endif

  typedef enum logic [1:0] {
    FETCH,
    EXEC
`ifdef PC_BOUNDS_EN
    , FAULT
`endif
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic        req_q, req_d;
  logic        flush_q, flush_d;
  logic        link_we_q, link_we_d;
  logic [31:0] link_data_q, link_data_d;
`ifdef PC_BOUNDS_EN
  logic        fault_q, fault_d;
  logic        out_of_range;
`endif

  logic        is_branch, is_jump, is_jal;
  logic [31:0] seq_pc, seq_masked, target, next_pc;

  always_comb begin
    is_branch  = (instr_ID >= 32'd15) && (instr_ID <= 32'd20);
    is_jump    = (instr_ID >= 32'd21) && (instr_ID <= 32'd23);
    is_jal     = (instr_ID == 32'd23);
    seq_pc     = pc_q + 32'd1;
    seq_masked = seq_pc & ADDR_MASK;
    if (is_branch)    target = seq_pc + br_out;
    else if (is_jump) target = br_out;
    else              target = seq_pc;
    next_pc    = target & ADDR_MASK;
`ifdef PC_BOUNDS_EN
    // Only branch/jump targets are range-checked; plain sequential flow wraps at the top.
    out_of_range = (is_branch || is_jump) && (target[31] || (target >= DEPTH_W));
`endif
  end

  // NOTE: every signal is given a default before the case so no path leaves it unassigned,
  // which is what keeps this block from inferring latches.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    req_d       = req_q;
    flush_d     = 1'b0;
    link_we_d   = 1'b0;
    link_data_d = link_data_q;
`ifdef PC_BOUNDS_EN
    fault_d     = fault_q;
`endif
    case (state_q)
      FETCH: begin
        // req rises one cycle after reset; an ack seen while req is low is stale and dropped.
        req_d = 1'b1;
        if (req_q && imem.imem_ack) begin
          ir_d    = imem.imem_rdata;
          req_d   = 1'b0;
          state_d = EXEC;
        end
      end
      EXEC: begin
        req_d = 1'b0;
        if (exec_valid) begin
`ifdef PC_BOUNDS_EN
          if (out_of_range) begin
            state_d = FAULT;
            fault_d = 1'b1;
          end else
`endif
          begin
            pc_d      = next_pc;
            state_d   = FETCH;
            req_d     = 1'b1;
            flush_d   = (next_pc != seq_masked);
            if (is_jal) begin
              link_we_d   = 1'b1;
              link_data_d = seq_masked;
            end
          end
        end
      end
`ifdef PC_BOUNDS_EN
      FAULT: req_d = 1'b0;
`endif
      default: begin
        state_d = FETCH;
        req_d   = 1'b0;
      end
    endcase
  end

  // NOTE: non-blocking assignments for all state so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FETCH;
      pc_q        <= RESET_PC;
      ir_q        <= 32'd0;
      req_q       <= 1'b0;
      flush_q     <= 1'b0;
      link_we_q   <= 1'b0;
      link_data_q <= 32'd0;
`ifdef PC_BOUNDS_EN
      fault_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      req_q       <= req_d;
      flush_q     <= flush_d;
      link_we_q   <= link_we_d;
      link_data_q <= link_data_d;
`ifdef PC_BOUNDS_EN
      fault_q     <= fault_d;
`endif
    end
  end

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = pc_q;
  assign ir_out         = ir_q;
  assign ir_valid       = (state_q == EXEC);
  assign pc             = pc_q;
  assign flush          = flush_q;
  assign link_we        = link_we_q;
  assign link_addr      = 5'(LINK_REG);
  assign link_data      = link_data_q;
`ifdef PC_BOUNDS_EN
  assign pc_fault       = fault_q;
`else
  assign pc_fault       = 1'b0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: stimulus pushes expected fetch/redirect results,
// a monitor pops them when ir_valid rises (fetch) or falls (redirect or fault).
module tb_pc_sequencer;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ir_out, instr_ID, br_out, pc, link_data;
  logic        ir_valid, exec_valid, flush, link_we, pc_fault;
  logic [4:0]  link_addr;

  pc_sequencer_if imem_if ();

  pc_sequencer #(.RESET_PC(32'd0), .IMEM_DEPTH(1024), .LINK_REG(31)) dut (
    .clk(clk), .rst(rst), .imem(imem_if.master),
    .ir_out(ir_out), .ir_valid(ir_valid),
    .exec_valid(exec_valid), .instr_ID(instr_ID), .br_out(br_out),
    .pc(pc), .flush(flush), .link_we(link_we), .link_addr(link_addr),
    .link_data(link_data), .pc_fault(pc_fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        flush;
    logic        link_we;
    logic [31:0] link_data;
    logic        imem_req;
    logic        pc_fault;
  } redir_t;

  typedef struct {
    logic [31:0] rdata;
    int          ack_wait;
    logic [31:0] id;
    logic [31:0] br;
    int          hold;
    logic [31:0] pc;
    logic        flush;
    logic        link_we;
    logic [31:0] link_data;
  } vec_t;

  logic [31:0] fetch_q[$];
  redir_t      redir_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] model_pc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Monitor: compares against the scoreboard whenever the DUT presents a result.
  initial begin : monitor
    logic   prev_valid, prev_flush, prev_link;
    redir_t r;
    prev_valid = 1'b0; prev_flush = 1'b0; prev_link = 1'b0;
    forever begin
      @(negedge clk);
      if (rst === 1'b1) begin
        prev_valid = 1'b0; prev_flush = 1'b0; prev_link = 1'b0;
      end else begin
        if (prev_flush) check("flush_one_cycle", 32'(flush), 32'd0);
        if (prev_link)  check("link_we_one_cycle", 32'(link_we), 32'd0);
        if (ir_valid && !prev_valid) begin
          if (fetch_q.size() == 0) check("unexpected_fetch", 32'(ir_valid), 32'd0);
          else check("ir_out", ir_out, fetch_q.pop_front());
        end
        if (!ir_valid && prev_valid) begin
          if (redir_q.size() == 0) check("unexpected_redirect", 32'(ir_valid), 32'd1);
          else begin
            r = redir_q.pop_front();
            check("pc", pc, r.pc);
            check("imem_addr", imem_if.imem_addr, r.pc);
            check("imem_req", 32'(imem_if.imem_req), 32'(r.imem_req));
            check("flush", 32'(flush), 32'(r.flush));
            check("link_we", 32'(link_we), 32'(r.link_we));
            check("link_data", link_data, r.link_data);
            check("link_addr", 32'(link_addr), 32'd31);
            check("pc_fault", 32'(pc_fault), 32'(r.pc_fault));
          end
        end
        prev_valid = ir_valid;
        prev_flush = flush;
        prev_link  = link_we;
      end
    end
  end

  task automatic run_instr(input vec_t v, input logic exp_fault);
    int     waited;
    redir_t r;
    fetch_q.push_back(v.rdata);
    waited = 0;
    while (imem_if.imem_req !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (imem_if.imem_req !== 1'b1) begin
      check("imem_req_timeout", 32'(imem_if.imem_req), 32'd1);
      return;
    end
    for (int i = 0; i < v.ack_wait; i++) begin
      check("imem_addr_held", imem_if.imem_addr, model_pc);
      @(negedge clk);
    end
    check("imem_addr_at_ack", imem_if.imem_addr, model_pc);
    imem_if.imem_ack   = 1'b1;
    imem_if.imem_rdata = v.rdata;
    @(negedge clk);
    imem_if.imem_ack   = 1'b0;
    imem_if.imem_rdata = 32'h0;
    r.pc = v.pc; r.flush = v.flush; r.link_we = v.link_we; r.link_data = v.link_data;
    r.imem_req = !exp_fault; r.pc_fault = exp_fault;
    redir_q.push_back(r);
    exec_valid = 1'b1;
    instr_ID   = v.id;
    br_out     = v.br;
    repeat (v.hold) @(negedge clk);
    exec_valid = 1'b0;
    instr_ID   = 32'd0;
    br_out     = 32'd0;
    model_pc   = v.pc;
  endtask

  vec_t vecs[11] = '{
    '{32'hDEAD0001, 2, 32'd21, 32'd5,          1, 32'd5,   1'b1, 1'b0, 32'd0},
    '{32'h00000011, 0, 32'd15, 32'd10,         1, 32'd16,  1'b1, 1'b0, 32'd0},
    '{32'h00000012, 1, 32'd21, 32'd5,          1, 32'd5,   1'b1, 1'b0, 32'd0},
    '{32'h00000013, 0, 32'd15, 32'd0,          2, 32'd6,   1'b0, 1'b0, 32'd0},
    '{32'h00000014, 0, 32'd21, 32'd20,         1, 32'd20,  1'b1, 1'b0, 32'd0},
    '{32'h00000015, 3, 32'd16, 32'hFFFFFFFC,   1, 32'd17,  1'b1, 1'b0, 32'd0},
    '{32'h00000016, 0, 32'd21, 32'd40,         1, 32'd40,  1'b1, 1'b0, 32'd0},
    '{32'h00000017, 0, 32'd23, 32'd100,        1, 32'd100, 1'b1, 1'b1, 32'd41},
    '{32'h00000018, 1, 32'd3,  32'd777,        1, 32'd101, 1'b0, 1'b0, 32'd41},
    '{32'h00000019, 0, 32'd22, 32'd50,         1, 32'd50,  1'b1, 1'b0, 32'd41},
    '{32'h0000001A, 0, 32'd21, 32'd10,         1, 32'd10,  1'b1, 1'b0, 32'd41}
  };

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    vec_t v;
    rst = 1'b1;
    exec_valid = 1'b0; instr_ID = 32'd0; br_out = 32'd0;
    imem_if.imem_ack = 1'b0; imem_if.imem_rdata = 32'h0;
    model_pc = 32'd0;
    repeat (2) @(negedge clk);
    check("rst_pc", pc, 32'd0);
    check("rst_imem_req", 32'(imem_if.imem_req), 32'd0);
    check("rst_imem_addr", imem_if.imem_addr, 32'd0);
    check("rst_ir_out", ir_out, 32'd0);
    check("rst_ir_valid", 32'(ir_valid), 32'd0);
    check("rst_flush", 32'(flush), 32'd0);
    check("rst_link_we", 32'(link_we), 32'd0);
    check("rst_link_data", link_data, 32'd0);
    check("rst_pc_fault", 32'(pc_fault), 32'd0);
    rst = 1'b0;

    foreach (vecs[i]) run_instr(vecs[i], 1'b0);

`ifdef PC_BOUNDS_EN
    v = '{32'h0000001B, 0, 32'd21, 32'd1030, 1, 32'd10, 1'b0, 1'b0, 32'd41};
    run_instr(v, 1'b1);
    repeat (5) begin
      @(negedge clk);
      check("fault_sticky", 32'(pc_fault), 32'd1);
      check("fault_pc_hold", pc, 32'd10);
      check("fault_no_req", 32'(imem_if.imem_req), 32'd0);
      check("fault_ir_valid", 32'(ir_valid), 32'd0);
    end
`else
    v = '{32'h0000001B, 0, 32'd21, 32'd1030, 1, 32'd6, 1'b1, 1'b0, 32'd41};
    run_instr(v, 1'b0);
`endif

    // Reset lands in the same cycle as an acknowledge; the ack must be discarded.
    rst = 1'b1;
    imem_if.imem_ack   = 1'b1;
    imem_if.imem_rdata = 32'hBAD0BAD0;
    @(negedge clk);
    rst = 1'b0;
    imem_if.imem_ack   = 1'b0;
    imem_if.imem_rdata = 32'h0;
    check("rst_ack_pc", pc, 32'd0);
    check("rst_ack_ir_valid", 32'(ir_valid), 32'd0);
    check("rst_ack_ir_out", ir_out, 32'd0);
    check("rst_ack_imem_req", 32'(imem_if.imem_req), 32'd0);
    check("rst_ack_pc_fault", 32'(pc_fault), 32'd0);
    model_pc = 32'd0;

    v = '{32'hCAFE0002, 0, 32'd21, 32'd3, 1, 32'd3, 1'b1, 1'b0, 32'd0};
    run_instr(v, 1'b0);

    repeat (3) @(negedge clk);
    check("fetch_queue_drained", 32'(fetch_q.size()), 32'd0);
    check("redirect_queue_drained", 32'(redir_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter sequencer that sits downstream of the branch unit. It fetches each instruction from instruction memory over a request/acknowledge handshake and presents it to decode. It then waits for execution to complete and uses the branch unit's result to choose the next PC. It also produces the jump-and-link write-back and a one-cycle pipeline flush whenever control flow leaves the sequential path.

## Interface
Parameters:
- RESET_PC, 0 — PC value loaded on reset.
- IMEM_DEPTH, 1024 — instruction memory depth in words; must be a power of 2.
- LINK_REG, 31 — register index written by jal.

Ports:
- clk  input  1  — single clock; all state updates on the rising edge.
- rst  input  1  — synchronous, active-high reset.
- imem_req  output  1  — fetch request.
- imem_addr  output  32  — word address of the fetch.
- imem_ack  input  1  — memory acknowledge; imem_rdata is valid in the same cycle.
- imem_rdata  input  32  — fetched instruction word.
- ir_out  output  32  — instruction register presented to decode.
- ir_valid  output  1  — ir_out is valid and awaiting execution.
- exec_valid  input  1  — execution of ir_out is complete; instr_ID and br_out are valid.
- instr_ID  input  32  — decoded instruction ID.
- br_out  input  32  — branch unit result: signed offset for IDs 15–20, absolute target for IDs 21–23.
- pc  output  32  — current PC.
- flush  output  1  — one-cycle pulse after a non-sequential PC change.
- link_we  output  1  — one-cycle link register write enable.
- link_addr  output  5  — equals LINK_REG.
- link_data  output  32  — return address (old pc + 1).
- pc_fault  output  1  — out-of-range target detected; present only with PC_BOUNDS_EN, otherwise tied 0.

## Operation
- States: FETCH, EXEC, FAULT (FAULT exists only with PC_BOUNDS_EN).
- Reset values: state=FETCH, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, ir_out=0, ir_valid=0, flush=0, link_we=0, link_data=0, pc_fault=0.
- FETCH:
  - imem_req=1 and imem_addr=pc, both held stable until imem_ack.
  - On imem_ack: ir_out<=imem_rdata and the state moves to EXEC.
  - exec_valid is ignored in this state.
- EXEC:
  - ir_valid=1 and imem_req=0; imem_ack is ignored.
  - On exec_valid, next PC is selected by instr_ID:
    - IDs 15–20: pc + 1 + br_out, with br_out treated as signed.
    - IDs 21–23: br_out.
    - Any other ID: pc + 1.
  - The next PC is reduced modulo IMEM_DEPTH and loaded into pc. The state returns to FETCH.
- flush: asserted for one cycle when the new pc differs from old pc + 1 (mod IMEM_DEPTH). A conditional branch with br_out=0 is sequential and does not flush.
- jal (ID 23): link_we=1 for one cycle, with link_data = old pc + 1 (mod IMEM_DEPTH).
- Arithmetic is 32-bit two's complement; the mod-IMEM_DEPTH reduction is a mask of log2(IMEM_DEPTH) low bits.

## Timing
- Fetch latency: imem_ack in cycle N gives ir_valid=1 in cycle N+1. An ack arriving in the same cycle as imem_req rises is legal.
- Redirect latency: exec_valid in cycle N gives the new pc, imem_req=1 with the new imem_addr, and any flush/link_we pulse, all in cycle N+1.
- Minimum loop is 2 cycles per instruction.
- Reset mid-fetch: imem_req drops in the cycle after rst is sampled, and any pending ack is discarded.
- exec_valid held high across several cycles is consumed once per EXEC visit.

## Configuration
- PC_BOUNDS_EN defined:
  - A computed target is in fault when it is ≥ IMEM_DEPTH or negative (as signed), evaluated before masking.
  - On fault the state moves to FAULT: pc is unchanged, pc_fault=1 sticky, imem_req=0, ir_valid=0, no flush, and link_we is suppressed.
  - Only rst leaves FAULT.
- PC_BOUNDS_EN undefined: targets wrap modulo IMEM_DEPTH silently, pc_fault is constant 0, and no FAULT state exists.

## Test plan
- Reset with RESET_PC=0, then ack after 2 cycles returning 0xDEAD0001 → imem_addr=0 held through the wait; ir_out=0xDEAD0001 and ir_valid=1 the cycle after the ack.
- pc=5, ID 15, br_out=10 → pc=16 and flush=1 for exactly one cycle. Repeat with br_out=0 → pc=6 and flush=0.
- pc=20, ID 16, br_out=0xFFFFFFFC (−4) → pc=17 and flush=1.
- pc=40, ID 23, br_out=100 → pc=100, link_we=1 for one cycle, link_addr=31, link_data=41.
- IMEM_DEPTH=1024, pc=10, ID 21, br_out=1030:
  - Without PC_BOUNDS_EN → pc=6.
  - With PC_BOUNDS_EN → pc stays 10, pc_fault=1 and stays set, imem_req=0 until rst.
- rst asserted in a cycle where imem_ack=1 → the next cycle has pc=RESET_PC, ir_valid=0, and ir_out=0.
